alu_seq_shifter: RTL

Multi-cycle, parametrised shift unit that succeeds the single-cycle LSL path of the alu. It performs LSL, LSR, ASR and ROR by shifting STEP bit positions per clock, under a start/busy/done handshake. The result and flags are written to registered outputs on completion. It sits beside the alu in the datapath, shares its operand and result naming, and keeps the LSL opcode encoding.

---
 rtl/alu_seq_shifter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shift unit beside the alu, shifting up to STEP bits per clock.
// Latency: max(1, ceil(k/STEP)) clocks from the accepting edge to the done pulse.
// Backpressure: busy is high while shifting and start is ignored then; start is accepted in IDLE or DONE.
module alu_seq_shifter #(
    parameter int W    = 16,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);

    // Remaining-count width must hold the value W itself (saturated amount).
    localparam int RW = $clog2(W + 1);

    localparam logic [4:0]    OP_LSL = 5'b00011;
    localparam logic [4:0]    OP_LSR = 5'b00100;
    localparam logic [4:0]    OP_ASR = 5'b00101;
    localparam logic [4:0]    OP_ROR = 5'b00110;

    localparam logic [W-1:0]  W_VAL  = W'(W);
    localparam logic [RW-1:0] W_R    = RW'(W);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [4:0]     r_op;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_work;
    logic [RW-1:0]  r_rem;

    logic           w_accept;
    logic           w_supported;
    logic [W-1:0]   w_mod;
    logic [RW-1:0]  w_k;
    logic           w_zero_path;

    logic [RW-1:0]  w_s;
    logic           w_last;
    logic [2*W-1:0] w_ext;
    logic [W-1:0]   w_step_res;
    logic           w_step_c;
    logic [3:0]     w_fin_flags;

    // Effective amount: ROR wraps modulo W, the linear shifts saturate at W.
    always_comb begin
        w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_supported = (alu_op == OP_LSL) || (alu_op == OP_LSR) ||
                      (alu_op == OP_ASR) || (alu_op == OP_ROR);
        w_mod       = operandB % W_VAL;
        if (alu_op == OP_ROR) begin
            w_k = w_mod[RW-1:0];
        end else if (operandB >= W_VAL) begin
            w_k = W_R;
        end else begin
            w_k = operandB[RW-1:0];
        end
        w_zero_path = !w_supported || (w_k == '0);
    end

    // One shift step of min(STEP, remaining) positions, with the last bit shifted out.
    always_comb begin
        w_s        = (r_rem > STEP_R) ? STEP_R : r_rem;
        w_last     = (r_rem == w_s);
        w_ext      = '0;
        w_step_res = r_work;
        w_step_c   = 1'b0;
        case (r_op)
            OP_LSL: begin
                // Upper half collects the bits pushed out; its LSB is the last one.
                w_ext      = {{W{1'b0}}, r_work} << w_s;
                w_step_res = w_ext[W-1:0];
                w_step_c   = w_ext[W];
            end
            OP_LSR: begin
                w_ext      = {r_work, {W{1'b0}}} >> w_s;
                w_step_res = w_ext[2*W-1:W];
                w_step_c   = w_ext[W-1];
            end
            OP_ASR: begin
                w_ext      = $signed({r_work, {W{1'b0}}}) >>> w_s;
                w_step_res = w_ext[2*W-1:W];
                w_step_c   = w_ext[W-1];
            end
            OP_ROR: begin
                w_ext      = {r_work, r_work} >> w_s;
                w_step_res = w_ext[W-1:0];
                w_step_c   = w_ext[W-1];
            end
            default: begin
                w_ext      = '0;
                w_step_res = r_work;
                w_step_c   = 1'b0;
            end
        endcase
        w_fin_flags = {w_step_res[W-1],
                       (w_step_res == '0),
                       w_step_c,
                       (r_op == OP_LSL) && (w_step_res[W-1] != r_opa[W-1])};
    end

    // State register; reset dominates everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero_path ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = w_zero_path ? S_DONE : S_SHIFT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, stepwise shifting, and result/flag update on completion only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op              <= '0;
            r_opa             <= '0;
            r_work            <= '0;
            r_rem             <= '0;
            resultAccumulator <= '0;
            flags             <= '0;
        end else if (w_accept) begin
            r_op   <= alu_op;
            r_opa  <= operandA;
            r_work <= operandA;
            r_rem  <= w_k;
            if (w_zero_path) begin
                // Nothing shifted out: carry and overflow stay clear.
                resultAccumulator <= operandA;
                flags             <= {operandA[W-1], (operandA == '0), 2'b00};
            end
        end else if (r_state == S_SHIFT) begin
            r_work <= w_step_res;
            r_rem  <= r_rem - w_s;
            if (w_last) begin
                resultAccumulator <= w_step_res;
                flags             <= w_fin_flags;
            end
        end
    end

endmodule
